// File: rtl/uart_pkg.sv
// Shared FSM state type, register map and helpers for mmio_uart_tx.
// Optional macro UART_PARITY_EN adds the PARITY state and the even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [31:0] OFS_DATA = 32'd0;
    localparam logic [31:0] OFS_CTRL = 32'd4;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with push, pop and flush; flush beats a same-cycle push.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_ZERO);
        do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: data register at BASE_ADDR, control at BASE_ADDR+4.
// Define UART_PARITY_EN for 11-bit frames with an even-parity bit after the data.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] DATA_ADR = BASE_ADDR + OFS_DATA;
    localparam logic [31:0] CTRL_ADR = BASE_ADDR + OFS_CTRL;
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    uart_state_t    state_r, state_nxt_s;
    logic [15:0]    cnt_r, cnt_nxt_s;
    logic [2:0]     idx_r, idx_nxt_s;
    logic [7:0]     shift_r, shift_nxt_s;
    logic           tx_r, tx_nxt_s;
    logic           ovf_r;
`ifdef UART_PARITY_EN
    logic           par_r, par_nxt_s;
`endif
    logic           data_wr_s, ctrl_wr_s, flush_s, clr_ovf_s, drop_s;
    logic           pop_s, bit_end_s;
    logic [7:0]     fifo_rdata_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_full_s, fifo_empty_s;
    logic           unused_wdata_s;

    assign data_wr_s      = MemWrite && (DataAdr == DATA_ADR);
    assign ctrl_wr_s      = MemWrite && (DataAdr == CTRL_ADR);
    assign flush_s        = ctrl_wr_s && WriteData[CTRL_FLUSH];
    assign clr_ovf_s      = ctrl_wr_s && WriteData[CTRL_CLR_OVF];
    assign drop_s         = data_wr_s && fifo_full_s && !pop_s;
    assign unused_wdata_s = ^WriteData[31:8];

    uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr_s),
        .wdata (WriteData[7:0]),
        .pop   (pop_s),
        .flush (flush_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencing; tx is precomputed from the next state so it leaves a flop.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        pop_s       = 1'b0;
`ifdef UART_PARITY_EN
        par_nxt_s   = par_r;
`endif
        bit_end_s   = (cnt_r == CNT_LAST);
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = 16'd0;
                    shift_nxt_s = fifo_rdata_s;
                    pop_s       = 1'b1;
`ifdef UART_PARITY_EN
                    par_nxt_s   = even_parity(fifo_rdata_s);
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s = DATA;
                    cnt_nxt_s   = 16'd0;
                    idx_nxt_s   = 3'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_nxt_s   = 16'd0;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = STOP;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end_s && !fifo_empty_s) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = 16'd0;
                    shift_nxt_s = fifo_rdata_s;
                    pop_s       = 1'b1;
`ifdef UART_PARITY_EN
                    par_nxt_s   = even_parity(fifo_rdata_s);
`endif
                end else if (bit_end_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase

        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_nxt_s = par_nxt_s;
`endif
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // FSM and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
`ifdef UART_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            tx_r    <= tx_nxt_s;
`ifdef UART_PARITY_EN
            par_r   <= par_nxt_s;
`endif
        end
    end

    // Sticky overflow flag, cleared only through the control register.
    always_ff @(posedge clk) begin
        if (reset || clr_ovf_s) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end
    end

    assign tx        = tx_r;
    assign overflow  = ovf_r;
    assign busy      = (state_r != IDLE) || (fifo_count_s != CNT_ZERO);
    assign fifo_full = fifo_full_s;

endmodule
